// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage access unit.
//   state_t         - access FSM encoding (IDLE / ACCESS / HOLD)
//   *_DEFAULT       - default bus widths and timeout length
//   ERR_*           - error cause codes, used when reporting errors
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int unsigned ADDR_W_DEFAULT  = 32;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: cycle counter bounding how long a bus access may wait.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - synchronous clear (priority over enable)
//   enable   - count one cycle
//   expired  - count has reached TIMEOUT_CYCLES-1
module mem_timeout_ctr
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

    // Holds at the terminal value so a stuck enable cannot wrap around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator issuing one word access per
// instruction on a req/ack data bus.
//   clk, rst                    - clock, asynchronous active-high reset
//   mem_read_i, mem_write_i     - EX/MEM control bits
//   addr_i, wdata_i             - ALU result (byte address), store data
//   bus_req_o, bus_we_o         - access request and direction
//   bus_addr_o, bus_wdata_o     - registered address / write data
//   bus_ack_i, bus_rdata_i      - responder completion pulse and read data
//   stall_o                     - freeze upstream pipeline registers
//   rdata_o, rdata_valid_o      - last load data and completion pulse
//   err_o, err_addr_o           - error pulse and address of the errored access
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W         = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    state_t state;
    logic   request;
    logic   misaligned;
    logic   both_set;
    logic   legal_req;
    logic   expired;

    assign request    = mem_read_i | mem_write_i;
    assign misaligned = (addr_i[1:0] != 2'b00);
    assign both_set   = mem_read_i & mem_write_i;
    assign legal_req  = request & ~misaligned & ~both_set;

    // Gated by rst so the pipeline is released the moment reset asserts,
    // even if the EX/MEM control bits are still high.
    assign stall_o = ~rst & (((state == IDLE) & legal_req) | (state == ACCESS));

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ACCESS),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            err_addr_o    <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal_req) begin
                        bus_addr_o  <= addr_i;
                        bus_wdata_o <= wdata_i;
                        bus_we_o    <= mem_write_i;
                        bus_req_o   <= 1'b1;
                        state       <= ACCESS;
                    end else if (request) begin
                        err_o      <= 1'b1;
                        err_addr_o <= addr_i;
                        state      <= HOLD;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so a same-cycle ack beats the timeout.
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            rdata_o       <= bus_rdata_i;
                            rdata_valid_o <= 1'b1;
                        end
                        state <= HOLD;
                    end else if (expired) begin
                        bus_req_o  <= 1'b0;
                        err_o      <= 1'b1;
                        err_addr_o <= bus_addr_o;
                        state      <= HOLD;
                    end
                end
                // One unstalled cycle lets EX/MEM advance so the same
                // instruction is not issued twice.
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
